// File: rtl/ddr_pkg.sv
// Shared types and constants for the note sequencer: state encoding,
// LFSR tap mask and the bit fields that decode a lane pattern from the LFSR.
package ddr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_PLAY,
        S_TAIL,
        S_DONE
    } state_t;

    localparam int unsigned NUM_LANES = 4;

    // Feedback taps on bits 7,5,4,3 (maximal-length 8-bit sequence)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int unsigned LANE_LSB       = 0;
    localparam int unsigned CHORD_LANE_LSB = 2;
    localparam int unsigned REST_LSB       = 2;
    localparam int unsigned REST_MSB       = 4;
    localparam int unsigned CHORD_LSB      = 5;
    localparam int unsigned CHORD_MSB      = 7;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_decode(input logic [7:0] l);
        logic [NUM_LANES-1:0] lanes;
        lanes = '0;
        if (l[REST_MSB:REST_LSB] != '0) begin
            lanes[l[LANE_LSB +: 2]] = 1'b1;
            if (l[CHORD_MSB:CHORD_LSB] == '1)
                lanes[l[CHORD_LANE_LSB +: 2]] = 1'b1;
        end
        return lanes;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running beat divider: counts 0..BEAT_CYCLES-1 while enabled and
// flags the terminal count as a one-cycle tick.
module beat_timer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = $clog2(BEAT_CYCLES);
    localparam logic [W-1:0] LAST = W'(BEAT_CYCLES - 1);

    logic [W-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= tick ? '0 : count + W'(1);
    end

endmodule

// File: rtl/note_scheduler.sv
// Song sequencer: lead-in countdown, one LFSR-chosen note per beat to the
// four lanes, a tail, then done. Clears the score when a song starts.
module note_scheduler
    import ddr_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned LEAD_BEATS  = 3,
    parameter int unsigned NUM_NOTES   = 32,
    parameter int unsigned TAIL_BEATS  = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    output logic [NUM_LANES-1:0] enable_lane,
    output logic                 resetscore,
    output logic [1:0]           lead_count,
    output logic [5:0]           note_index,
    output logic                 beat_tick,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned LW = $clog2(LEAD_BEATS + 1);
    localparam int unsigned TW = $clog2(TAIL_BEATS + 1);
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [5:0] LAST_NOTE = 6'(NUM_NOTES - 1);

    state_t        state;
    logic [7:0]    lfsr;
    logic [LW-1:0] lead_left;
    logic [TW-1:0] tail_left;
    logic [5:0]    issue_index;
    logic          tick;
    logic          launch;
    logic          issue;

    assign busy      = state inside {S_LEAD, S_PLAY, S_TAIL};
    assign done      = (state == S_DONE);
    assign launch    = start && (state == S_IDLE || state == S_DONE);
    assign issue     = tick && (state == S_PLAY || (state == S_LEAD && lead_left == LW'(1)));
    assign beat_tick = tick;
    assign lead_count = (state != S_LEAD)           ? 2'd0 :
                        (32'(lead_left) >= 32'd3)   ? 2'd3 : 2'(lead_left);

    beat_timer #(
        .BEAT_CYCLES(BEAT_CYCLES)
    ) u_beat_timer (
        .clk   (clk),
        .reset (reset),
        .clear (launch),
        .enable(busy && !pause),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            lead_left   <= '0;
            tail_left   <= '0;
            issue_index <= '0;
            note_index  <= '0;
            enable_lane <= '0;
            resetscore  <= 1'b0;
        end else begin
            enable_lane <= '0;
            resetscore  <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LEAD;
                        resetscore  <= 1'b1;
                        lead_left   <= LW'(LEAD_BEATS);
                        lfsr        <= SEED;
                        issue_index <= '0;
                        note_index  <= '0;
                    end
                end
                S_LEAD: begin
                    if (tick) begin
                        lead_left <= lead_left - LW'(1);
                        if (lead_left == LW'(1))
                            state <= S_PLAY;
                    end
                end
                S_PLAY: ;
                S_TAIL: begin
                    if (tick) begin
                        if (tail_left == TW'(1))
                            state <= S_DONE;
                        else
                            tail_left <= tail_left - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Issue is shared by the LEAD exit and PLAY; the last-note
            // transition here overrides the LEAD->PLAY assignment above.
            if (issue) begin
                enable_lane <= lane_decode(lfsr);
                lfsr        <= lfsr_next(lfsr);
                note_index  <= issue_index;
                if (issue_index == LAST_NOTE) begin
                    state     <= S_TAIL;
                    tail_left <= TW'(TAIL_BEATS);
                end else begin
                    issue_index <= issue_index + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: cycle-exact song timing, decode of
// several seeds, pause, restart, reset, and a long seed-0 run.
module tb_note_scheduler;

    logic clk, reset, start, pause, start_long;

    logic [3:0] a_lane, e6_lane, e1_lane, z0_lane, l_lane;
    logic       a_rs, e6_rs, e1_rs, z0_rs, l_rs;
    logic [1:0] a_lead, e6_lead, e1_lead, z0_lead, l_lead;
    logic [5:0] a_idx, e6_idx, e1_idx, z0_idx, l_idx;
    logic       a_tick, e6_tick, e1_tick, z0_tick, l_tick;
    logic       a_busy, e6_busy, e1_busy, z0_busy, l_busy;
    logic       a_done, e6_done, e1_done, z0_done, l_done;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] a5_seq [4];

    note_scheduler #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .NUM_NOTES(4), .TAIL_BEATS(1), .LFSR_SEED(8'hA5)) u_a5 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .enable_lane(a_lane), .resetscore(a_rs),
        .lead_count(a_lead), .note_index(a_idx), .beat_tick(a_tick), .busy(a_busy), .done(a_done));

    note_scheduler #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .NUM_NOTES(4), .TAIL_BEATS(1), .LFSR_SEED(8'hE6)) u_e6 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .enable_lane(e6_lane), .resetscore(e6_rs),
        .lead_count(e6_lead), .note_index(e6_idx), .beat_tick(e6_tick), .busy(e6_busy), .done(e6_done));

    note_scheduler #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .NUM_NOTES(4), .TAIL_BEATS(1), .LFSR_SEED(8'hE1)) u_e1 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .enable_lane(e1_lane), .resetscore(e1_rs),
        .lead_count(e1_lead), .note_index(e1_idx), .beat_tick(e1_tick), .busy(e1_busy), .done(e1_done));

    note_scheduler #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .NUM_NOTES(4), .TAIL_BEATS(1), .LFSR_SEED(8'h00)) u_z0 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .enable_lane(z0_lane), .resetscore(z0_rs),
        .lead_count(z0_lead), .note_index(z0_idx), .beat_tick(z0_tick), .busy(z0_busy), .done(z0_done));

    note_scheduler #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .NUM_NOTES(63), .TAIL_BEATS(1), .LFSR_SEED(8'h00)) u_long (
        .clk(clk), .reset(reset), .start(start_long), .pause(pause), .enable_lane(l_lane), .resetscore(l_rs),
        .lead_count(l_lead), .note_index(l_idx), .beat_tick(l_tick), .busy(l_busy), .done(l_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_lane"}, 32'(a_lane), 0);
        check({tag, "_rs"},   32'(a_rs),   0);
        check({tag, "_lead"}, 32'(a_lead), 0);
        check({tag, "_idx"},  32'(a_idx),  0);
        check({tag, "_tick"}, 32'(a_tick), 0);
        check({tag, "_busy"}, 32'(a_busy), 0);
        check({tag, "_done"}, 32'(a_done), 0);
    endtask

    function automatic logic [3:0] model_lanes(input logic [7:0] l);
        logic [3:0] v;
        v = 4'b0000;
        if (l[4:2] != 3'b000) begin
            v = 4'b0001 << l[1:0];
            if (l[7:5] == 3'b111)
                v = v | (4'b0001 << l[3:2]);
        end
        return v;
    endfunction

    // Start a song at r=0; optionally pulse start mid-song, pause 10 cycles
    // from pause_at, or reset at reset_at. eff maps wall cycle to song time.
    task automatic run_song(input int start_at, input int pause_at, input int reset_at, input bit seeds);
        int  last_r, eff, k;
        bit  paused;
        last_r = (pause_at > 0) ? 36 : 26;
        start = 1'b1;
        step();
        for (int r = 1; r <= last_r; r++) begin
            paused = (pause_at > 0) && (r >= pause_at) && (r < pause_at + 10);
            start  = (r == start_at);
            pause  = paused;
            reset  = (r == reset_at);
            #1;
            if (reset_at > 0 && r == reset_at + 1) begin
                check_idle($sformatf("post_reset@%0d", r));
                break;
            end
            eff = (pause_at == 0 || r < pause_at) ? r : ((r < pause_at + 10) ? pause_at : r - 10);
            k = (eff - 9) / 4;
            check($sformatf("lane@%0d", r), 32'(a_lane),
                  (eff >= 9 && eff <= 21 && (eff - 9) % 4 == 0) ? 32'(a5_seq[k]) : 0);
            check($sformatf("rs@%0d", r), 32'(a_rs), (eff == 1) ? 1 : 0);
            check($sformatf("lead@%0d", r), 32'(a_lead),
                  (eff >= 1 && eff <= 4) ? 2 : ((eff >= 5 && eff <= 8) ? 1 : 0));
            check($sformatf("idx@%0d", r), 32'(a_idx), (eff < 9) ? 0 : ((k > 3) ? 3 : k));
            check($sformatf("tick@%0d", r), 32'(a_tick),
                  (!paused && eff >= 4 && eff <= 24 && eff % 4 == 0) ? 1 : 0);
            check($sformatf("busy@%0d", r), 32'(a_busy), (eff >= 1 && eff <= 24) ? 1 : 0);
            check($sformatf("done@%0d", r), 32'(a_done), (eff >= 25) ? 1 : 0);
            if (seeds && r == 9) begin
                check("e6_chord0", 32'(e6_lane), 32'h6);
                check("e1_rest0",  32'(e1_lane), 0);
                check("z0_rest0",  32'(z0_lane), 0);
            end
            if (seeds && r == 10)
                check("e1_idx0", 32'(e1_idx), 0);
            if (seeds && r == 13) begin
                check("e6_note1", 32'(e6_lane), 32'h1);
                check("e6_idx1",  32'(e6_idx),  1);
                check("e1_rest1", 32'(e1_lane), 0);
                check("e1_idx1",  32'(e1_idx),  1);
                check("z0_idx1",  32'(z0_idx),  1);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        pause = 1'b0;
        reset = 1'b0;
    endtask

    task automatic run_long_song(input int song);
        logic [7:0] m;
        m = 8'h01;
        start_long = 1'b1;
        step();
        start_long = 1'b0;
        check($sformatf("long%0d_rs", song), 32'(l_rs), 1);
        for (int r = 1; r <= 261; r++) begin
            if (r >= 9 && r <= 257 && (r - 9) % 4 == 0) begin
                check($sformatf("long%0d_lane%0d", song, (r - 9) / 4), 32'(l_lane), 32'(model_lanes(m)));
                check($sformatf("long%0d_idx%0d", song, (r - 9) / 4), 32'(l_idx), (r - 9) / 4);
                m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            end
            if (r == 261)
                check($sformatf("long%0d_done", song), 32'(l_done), 1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        a5_seq = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        start_long = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check_idle("reset");

        // pause while idle must not start anything
        pause = 1'b1;
        step();
        step();
        check("idle_pause_busy", 32'(a_busy), 0);
        check("idle_pause_tick", 32'(a_tick), 0);
        pause = 1'b0;
        step();

        run_song(0, 0, 0, 1'b1);   // basic song plus seed decode
        run_song(6, 0, 0, 1'b0);   // restart from DONE, start while busy ignored
        run_song(0, 14, 0, 1'b0);  // 10-cycle pause mid-PLAY
        run_song(0, 0, 15, 1'b0);  // reset mid-PLAY
        step();
        check_idle("after_reset");
        run_song(0, 0, 0, 1'b0);   // clean song after reset

        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("rst_start_busy", 32'(a_busy), 0);
        check("rst_start_rs",   32'(a_rs),   0);
        check("rst_start_done", 32'(a_done), 0);

        for (int s = 0; s < 5; s++)
            run_long_song(s);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
